// File: rtl/parity_pkg.sv
// Shared types and constants for the nibble framing transmitter.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam int NIBBLE_W   = 4;
  localparam int FRAME_BITS = 7;

endpackage

// File: rtl/parity_bit.sv
// Four-input even-parity generator; purely combinational, no handshake.
module parity_bit (
  input  logic inA,
  input  logic inB,
  input  logic inC,
  input  logic inD,
  output logic out
);

  assign out = inA ^ inB ^ inC ^ inD;

endmodule

// File: rtl/parity_frame_tx.sv
// Frames a nibble as start/4 data/parity/stop, 7*CLKS_PER_BIT cycles, first bit one cycle after accept.
// in_ready is low for the whole frame; in_valid is only honoured in IDLE.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                tx_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]     LAST_IDX = 2'(NIBBLE_W - 1);

  frame_state_t        r_state;
  frame_state_t        w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [1:0]          r_idx;
  logic [1:0]          w_idx_nxt;
  logic [NIBBLE_W-1:0] r_data;
  logic                r_par;
  logic                w_par;
  logic                w_load;
  logic                w_bit_end;
  logic                w_tx;
  logic                w_busy;
  logic                w_done;

  parity_bit u_parity_bit (
    .inA (r_data[0]),
    .inB (r_data[1]),
    .inC (r_data[2]),
    .inD (r_data[3]),
    .out (w_par)
  );

  assign w_bit_end = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      // data_q only settles once per frame, so par_q is valid long before PARITY
      r_par   <= w_par ^ ODD_PARITY;
      if (w_load) begin
        r_data <= in_data;
      end
    end
  end

  // Outputs decode registered state only; in_valid affects next-state alone.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_tx        = 1'b1;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy    = 1'b0;
        w_cnt_nxt = '0;
        if (in_valid) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_tx = r_data[r_idx];
        if (w_bit_end) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = PARITY;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      PARITY: begin
        w_tx = r_par;
        if (w_bit_end) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        w_done = w_bit_end;
        if (w_bit_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign tx_out     = w_tx;
  assign busy       = w_busy;
  assign in_ready   = ~w_busy;
  assign frame_done = w_done;

endmodule
